// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master drives requests and control; slave (the arbiter) drives grant status.
interface rr_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic             ena;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output ena, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  ena, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant one cycle after req is seen in IDLE.
// Grant is held until done, request drop, ena low or hold limit; one idle bubble follows.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             rel_early;
  logic             rel_hold;

  // Search upward from ptr; IDX_W-bit addition wraps because N is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && bus.req[ptr_q + IDX_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + IDX_W'(i);
      end
    end
  end

  assign rel_early = bus.done || !bus.req[idx_q] || !bus.ena;
  assign rel_hold  = (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ena && win_found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win_idx;
          idx_d   = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_early || rel_hold) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          // Only a pure hold-limit release is reported as a timeout.
          to_d    = rel_hold && !rel_early;
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = to_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_idx    : assert property (@(posedge clk) disable iff (rst)
                              (gnt_q == '0) || (gnt_q[idx_q] == 1'b1));

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: vector table plus hand sequences for hold limit and async reset.
module tb_rr_arbiter;
  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 15;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

  rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       ena;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [12:0] outs();
    return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got gnt/idx/vld/to=%h required %h", name, act, exp);
  endtask

  task automatic step(input logic e, input logic [7:0] r, input logic d);
    bus.ena  = e;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input string name, input logic e, input logic [7:0] r,
                             input logic d, input logic [7:0] g, input logic [2:0] i,
                             input logic v, input logic t);
    step(e, r, d);
    check(name, outs(), {g, i, v, t});
  endtask

  task automatic add(input logic e, input logic [7:0] r, input logic d, input logic [7:0] g,
                     input logic [2:0] i, input logic v, input logic t, input string name);
    vec_t x;
    x.ena = e; x.req = r; x.done = d; x.gnt = g; x.idx = i; x.vld = v; x.to = t; x.name = name;
    vecs.push_back(x);
  endtask

  initial begin
    bus.ena  = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;

    // ptr 0 -> grant 2, done -> ptr 3
    add(1, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_grant");
    add(1, 8'h04, 1, 8'h00, 3'd0, 0, 0, "single_done");
    // ptr 3, req 0,1 -> wrap to 0, then 1
    add(1, 8'h03, 0, 8'h01, 3'd0, 1, 0, "wrap_grant0");
    add(1, 8'h03, 1, 8'h00, 3'd0, 0, 0, "wrap_rel0");
    add(1, 8'h03, 0, 8'h02, 3'd1, 1, 0, "wrap_grant1");
    add(1, 8'h03, 1, 8'h00, 3'd0, 0, 0, "wrap_rel1");
    // ptr 2, all requesting: 2,3,...,7,0,1,2 with a bubble between each
    for (int k = 0; k < 9; k++) begin
      int o;
      o = (2 + k) % 8;
      add(1, 8'hFF, 0, 8'(1 << o), 3'(o), 1, 0, $sformatf("rot_grant%0d", k));
      add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0, $sformatf("rot_rel%0d", k));
    end
    // ptr 3: grant 6, drop req[6] with req[1] up -> release, then 1 via wrap from 7
    add(1, 8'h40, 0, 8'h40, 3'd6, 1, 0, "drop_grant6");
    add(1, 8'h02, 0, 8'h00, 3'd0, 0, 0, "drop_release");
    add(1, 8'h02, 0, 8'h02, 3'd1, 1, 0, "drop_next1");
    add(1, 8'h02, 1, 8'h00, 3'd0, 0, 0, "drop_rel1");
    // ptr 2: grant 6, ena low releases and blocks further grants
    add(1, 8'h40, 0, 8'h40, 3'd6, 1, 0, "ena_grant6");
    add(0, 8'h40, 0, 8'h00, 3'd0, 0, 0, "ena_release");
    add(0, 8'h40, 0, 8'h00, 3'd0, 0, 0, "ena_block1");
    add(0, 8'h42, 0, 8'h00, 3'd0, 0, 0, "ena_block2");
    add(1, 8'h00, 1, 8'h00, 3'd0, 0, 0, "idle_done_ignored");

    #2;
    check("reset_state", outs(), 13'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[n])
      expect_step(vecs[n].name, vecs[n].ena, vecs[n].req, vecs[n].done,
                  vecs[n].gnt, vecs[n].idx, vecs[n].vld, vecs[n].to);

    // ptr 7: requester 4 holds without done -> 15 grant cycles then timeout
    for (int c = 0; c < MAX_HOLD; c++)
      expect_step($sformatf("hold_cyc%0d", c), 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    expect_step("hold_timeout", 1, 8'h10, 0, 8'h00, 3'd0, 0, 1);
    expect_step("hold_regrant", 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    for (int c = 1; c < MAX_HOLD; c++)
      expect_step($sformatf("hold2_cyc%0d", c), 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    // done coincides with hold limit: release without timeout
    expect_step("hold_done_prec", 1, 8'h10, 1, 8'h00, 3'd0, 0, 0);

    // ptr 5: grant 7, then asynchronous reset mid-cycle
    expect_step("rst_grant7", 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clear", outs(), 13'h0);
    #1;
    rst = 1'b0;
    expect_step("rst_ptr0_grant0", 1, 8'h81, 0, 8'h01, 3'd0, 1, 0);
    expect_step("rst_rel0", 1, 8'h81, 1, 8'h00, 3'd0, 0, 0);
    expect_step("rst_next7", 1, 8'h81, 0, 8'h80, 3'd7, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource between N requesters. Typical resource: a shared datapath slot behind the priority-encoder stage.
- Registered one-hot grant plus encoded index.
- Grant is held until the owner signals done, drops its request, or exceeds a hold-time limit.
- Rotating priority pointer guarantees fairness. The block sits between request sources and the shared resource in the top-level tile.

Parameters:
- N, 8, number of requesters (power of two, 2..8)
- IDX_W, 3, width of grant index (log2 N)
- MAX_HOLD, 15, maximum grant cycles before forced release (1..255)
- CNT_W, 8, hold counter width (must hold MAX_HOLD)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- ena  input  1  arbitration enable; low blocks new grants and forces release
- req  input  N  request vector, bit i = requester i
- done  input  1  current owner finished; releases grant this cycle
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  IDX_W  index of current owner, registered; 0 when idle
- gnt_valid  output  1  high while any grant is active (equals OR of gnt)
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold counter=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If ena=1 and req!=0, select the first set req bit searching upward from ptr with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - Next edge: gnt/gnt_idx = winner, gnt_valid=1, counter=1, state=GRANT.
  - Otherwise stay in IDLE with outputs at 0.
  - Latency: req sampled at edge k gives gnt visible after edge k (one-cycle registered grant).
- GRANT, release conditions sampled each edge, any one true:
  - (a) done=1
  - (b) req[gnt_idx]=0
  - (c) ena=0
  - (d) counter==MAX_HOLD
- On release: gnt=0, gnt_idx=0, gnt_valid=0, ptr = (gnt_idx+1) mod N, counter=0, state=IDLE.
- timeout=1 for exactly one cycle only when (d) causes the release and (a)-(c) are all false. Any of (a)-(c) takes precedence, and timeout stays 0.
- Otherwise stay in GRANT, counter increments (saturates at MAX_HOLD, never wraps).
- Released owner's next grant: a release always returns to IDLE for one cycle (bubble), so back-to-back grants are separated by exactly one idle cycle. gnt never changes owner directly.
- Requests from other requesters while a grant is active are ignored (no preemption). Arbitration uses req as seen in the IDLE cycle.
- done asserted in IDLE is ignored. done and release-by-drop in the same cycle count as one release.
- ptr wraps: owner N-1 gives ptr=0.
- MAX_HOLD=1: grant lasts exactly one cycle, then timeout pulses if the owner is still requesting.
- rst asserted mid-grant: outputs clear immediately (asynchronously) and ptr returns to 0.
- gnt is always one-hot or zero. gnt_idx is consistent with gnt.

Test Plan:
- Reset, then req=8'b0000_0100, ena=1 -> one cycle later gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1. Assert done -> gnt=0 next cycle, ptr=3.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0, each grant separated by one idle cycle, no timeout.
- ptr=3 (after owner 2), req=8'b0000_0011 -> wrap search grants 0; then grants 1 after 0 releases.
- req=8'b0001_0000 held, done never asserted, MAX_HOLD=15 -> gnt high 15 cycles, timeout pulses exactly once on the release edge, ptr=5. Then with req unchanged, requester 4 is re-granted after one idle cycle.
- Grant to 6 active, req[6] dropped while req[1] high -> gnt=0 next cycle, timeout=0. Next grant goes to 1 (search from 7 wraps). Same scenario with ena dropped -> release, no new grant while ena=0.
- rst pulsed mid-grant, asynchronous to clk -> gnt, gnt_idx, gnt_valid clear immediately. After release, req=8'h80|8'h01 -> grants 0 first (ptr reset to 0).
